aes_key_expand: RTL
===================

# aes_key_expand

Iterative AES-128 key expansion engine for the encryption datapath. It sits downstream of the column-mixing stage and feeds the AddRoundKey stage that consumes each mixed 128-bit state. From one 128-bit cipher key it produces the 11 round keys (indices 0..10), one per valid/ready handshake. It computes each next key on the fly from the current one rather than storing a 176-byte schedule.

## Interface
Parameters: none (fixed AES-128: Nk=4, Nr=10).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new expansion.
  - Sampled only in IDLE; ignored otherwise.
- key_in  in  128  cipher key, captured on accepted start.
  - Word order: w0=[127:96], w1=[95:64], w2=[63:32], w3=[31:0].
  - Within each word, byte0 is the MSB byte. This matches the state column packing used by the mixing stage.
- rk_valid  out  1  rk_out/rk_index hold a valid round key.
- rk_ready  in  1  consumer accepts the current key when rk_valid & rk_ready at a clock edge.
- rk_out  out  128  current round key, same word/byte order as key_in.
- rk_index  out  4  round number of rk_out, 0..10.
- busy  out  1  high from accepted start until the final handshake.
- done  out  1  one-cycle pulse after key 10 is accepted.

## Operation
- States: IDLE and OUT.
- IDLE:
  - busy=0, rk_valid=0.
  - On start=1: register key_in into key_reg, set index=0, set rcon=8'h01, go to OUT.
- OUT:
  - rk_valid=1, rk_out=key_reg, rk_index=index.
  - On handshake with index<10: key_reg <= next_key(key_reg, rcon), index <= index+1, rcon <= xtime(rcon).
  - On handshake with index==10: go to IDLE and pulse done.
  - Without handshake: all outputs and registers hold (rk_out stable under backpressure).
- next_key, with w = {w0,w1,w2,w3} and w3 = {b0,b1,b2,b3}:
  - t = SubWord({b1,b2,b3,b0}) ^ {rcon,24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- SubWord uses four instances of the team's combinational 8-bit AES S-box.
- xtime(x) = x<<1, XORed with 8'h1b when x[7]=1. This is the same GF(2^8) doubling as the mixing stage.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- start while busy: ignored; no restart and no key_in capture.
- rst: state returns to IDLE from any state, including mid-expansion.
  - key_reg, rcon, index, and all outputs are cleared to 0.
  - Any expansion in progress is abandoned and done is not pulsed.

## Timing
- Reset values: rk_valid=0, rk_out=0, rk_index=0, busy=0, done=0.
- Latency: start accepted at edge N → at cycle N+1, rk_valid=1, rk_index=0, rk_out=key_in, busy=1.
- Key k+1 appears the cycle after key k's handshake.
- With rk_ready held high, keys 0..10 occupy 11 consecutive cycles.
- Final handshake at edge M → in cycle M+1: done=1, busy=0, rk_valid=0.
  - done deasserts at M+2.
  - A start in cycle M+1 is accepted (state is IDLE).
- rk_out, rk_index, and rk_valid are registered outputs; no combinational path from rk_ready or start to any output.
- done and busy are registered.

## Test plan
- Reset then idle: hold rst 2 cycles, then start=0 for 5 cycles -> rk_valid=0, busy=0, done=0, rk_out=0 throughout.
- FIPS-197 key, rk_ready=1: start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> rk_index 0..10 on 11 consecutive cycles. Required keys:
  - key 0 = key_in.
  - key 1 = a0fafe1788542cb123a339392a6c7605.
  - key 2 = f2c295f27a96b9435935807a7359f67f.
  - key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses exactly once, the cycle after key 10.
- Backpressure: same key, rk_ready low for 3 cycles at index 4 and for 1 cycle at index 10 -> rk_out/rk_index stable while stalled. Sequence identical to the previous case; done is delayed accordingly.
- Start while busy: assert start with a different key_in at index 5 -> ignored; remaining keys match the original schedule.
- Reset mid-operation: rst at index 6 -> next cycle all outputs 0, no done pulse. A fresh start afterwards yields the correct key 0 and key 1.
- Back-to-back runs: start in the done cycle with key_in=000102030405060708090a0b0c0d0e0f -> key 1 = d6aa74fdd2af72fadaa678f1d6ab76fe, key 10 = 13111d7fe3944a17f307a78b4d2b30c5.

Source files
------------

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key expansion: emits round keys 0..10 over a valid/ready
// handshake, deriving each next key from the current one on the fly.

module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    // Forward S-box, entry 0x00 in the top byte; ~byte_i selects from the MSB end.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byte_o = SBOX_TABLE[{~byte_i, 3'b000} +: 8];
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE = 1'b0, OUT = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   index_q, index_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;

    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  t_word;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [127:0] next_key;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    endfunction

    // RotWord of w3, then SubWord byte by byte
    assign rot_word = {key_q[23:0], key_q[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (rot_word[8*b +: 8]),
            .byte_o (sub_word[8*b +: 8])
        );
    end

    assign t_word   = sub_word ^ {rcon_q, 24'h0};
    assign nw0      = key_q[127:96] ^ t_word;
    assign nw1      = key_q[95:64]  ^ nw0;
    assign nw2      = key_q[63:32]  ^ nw1;
    assign nw3      = key_q[31:0]   ^ nw2;
    assign next_key = {nw0, nw1, nw2, nw3};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            index_q <= '0;
            rcon_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            index_q <= index_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = OUT;
            OUT:  if (rk_ready && index_q == 4'd10) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_d   = key_q;
        index_d = index_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    index_d = 4'd0;
                    rcon_d  = 8'h01;
                end
            end
            OUT: begin
                if (rk_ready) begin
                    if (index_q == 4'd10) begin
                        done_d = 1'b1;
                    end else begin
                        key_d   = next_key;
                        index_d = index_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs decode straight from flops; nothing passes combinationally from inputs.
    always_comb begin
        rk_valid = (state_q == OUT);
        busy     = (state_q == OUT);
        rk_out   = key_q;
        rk_index = index_q;
        done     = done_q;
    end
endmodule
